// File: rtl/input_chaining_pipe.sv
// rtl/input_chaining_pipe.sv - packs a DATA_WID word stream into MAX_CHAIN-word groups
//
// Collects words into a fill buffer and hands complete (or flushed partial)
// groups to a one-entry output buffer, so the next group can fill while the
// current one waits on a stalled consumer.
//
// Ports:
//   clk, rst        rising-edge clock, synchronous active-high reset
//   en              enables input acceptance; a partial group is held while low
//   cfg_len         words per group (0 or >MAX_CHAIN means MAX_CHAIN), sampled at group start
//   cfg_msb_first   packing order, sampled at group start
//   in_dat/in_vld/in_rdy     input word stream
//   flush           closes the current partial group
//   out_dat/out_vld/out_rdy  packed group stream
//   out_cnt         number of valid words in out_dat
//   done            one-cycle pulse the cycle after a group is consumed
module input_chaining_pipe #(
  parameter int DATA_WID  = 16,
  parameter int MAX_CHAIN = 4,
  parameter int CNT_WID   = $clog2(MAX_CHAIN + 1)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          en,
  input  logic [CNT_WID-1:0]            cfg_len,
  input  logic                          cfg_msb_first,
  input  logic [DATA_WID-1:0]           in_dat,
  input  logic                          in_vld,
  output logic                          in_rdy,
  input  logic                          flush,
  output logic [MAX_CHAIN*DATA_WID-1:0] out_dat,
  output logic                          out_vld,
  input  logic                          out_rdy,
  output logic [CNT_WID-1:0]            out_cnt,
  output logic                          done
);

  localparam int BUS_WID = MAX_CHAIN * DATA_WID;
  localparam logic [CNT_WID-1:0] MAX_CNT = CNT_WID'(MAX_CHAIN);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FILL,
    ST_FULL
  } fill_state_t;

  fill_state_t          state_q, state_d;
  logic [BUS_WID-1:0]   fill_dat_q, fill_dat_d;
  logic [CNT_WID-1:0]   fill_cnt_q, fill_cnt_d;
  logic [CNT_WID-1:0]   fill_len_q, fill_len_d;
  logic                 fill_msb_q, fill_msb_d;
  logic [BUS_WID-1:0]   out_dat_q, out_dat_d;
  logic [CNT_WID-1:0]   out_cnt_q, out_cnt_d;
  logic                 out_vld_q, out_vld_d;
  logic                 done_q;

  logic                 acc;
  logic                 drain;
  logic                 out_free;
  logic                 complete;
  logic [CNT_WID-1:0]   cur_len;
  logic                 cur_msb;
  logic [CNT_WID-1:0]   cnt_nxt;
  logic [BUS_WID-1:0]   dat_nxt;
  int                   slot;

  // Reset is folded in so the input side reads not-ready throughout reset.
  assign in_rdy  = en && !rst && (state_q != ST_FULL);
  assign acc     = in_vld && in_rdy;
  assign drain   = out_vld_q && out_rdy;
  assign out_free = !out_vld_q || out_rdy;

  assign out_dat = out_dat_q;
  assign out_cnt = out_cnt_q;
  assign out_vld = out_vld_q;
  assign done    = done_q;

  always_comb begin
    // The first word of a group takes the live configuration; later words
    // use the values latched with that first word.
    if (fill_cnt_q == '0) begin
      if (cfg_len == '0 || cfg_len > MAX_CNT) cur_len = MAX_CNT;
      else                                    cur_len = cfg_len;
      cur_msb = cfg_msb_first;
    end else begin
      cur_len = fill_len_q;
      cur_msb = fill_msb_q;
    end

    slot = cur_msb ? (MAX_CHAIN - 1 - int'(fill_cnt_q)) : int'(fill_cnt_q);

    cnt_nxt = fill_cnt_q + {{(CNT_WID-1){1'b0}}, acc};
    dat_nxt = fill_dat_q;
    for (int s = 0; s < MAX_CHAIN; s++) begin
      if (acc && s == slot) dat_nxt[s*DATA_WID +: DATA_WID] = in_dat;
    end

    // Flush counts a word accepted in the same cycle; FULL ignores flush.
    complete = (state_q != ST_FULL) &&
               ((acc && cnt_nxt == cur_len) || (flush && cnt_nxt != '0));
  end

  always_comb begin
    state_d    = state_q;
    fill_dat_d = fill_dat_q;
    fill_cnt_d = fill_cnt_q;
    fill_len_d = fill_len_q;
    fill_msb_d = fill_msb_q;
    out_dat_d  = out_dat_q;
    out_cnt_d  = out_cnt_q;
    out_vld_d  = out_vld_q && !out_rdy;

    if (acc) begin
      fill_len_d = cur_len;
      fill_msb_d = cur_msb;
    end

    if (state_q == ST_FULL) begin
      // The held group moves across on the drain edge, with no bubble.
      if (drain) begin
        out_dat_d  = fill_dat_q;
        out_cnt_d  = fill_cnt_q;
        out_vld_d  = 1'b1;
        fill_dat_d = '0;
        fill_cnt_d = '0;
        state_d    = ST_IDLE;
      end
    end else if (complete) begin
      if (out_free) begin
        out_dat_d  = dat_nxt;
        out_cnt_d  = cnt_nxt;
        out_vld_d  = 1'b1;
        fill_dat_d = '0;
        fill_cnt_d = '0;
        state_d    = ST_IDLE;
      end else begin
        fill_dat_d = dat_nxt;
        fill_cnt_d = cnt_nxt;
        state_d    = ST_FULL;
      end
    end else begin
      fill_dat_d = dat_nxt;
      fill_cnt_d = cnt_nxt;
      state_d    = (cnt_nxt == '0) ? ST_IDLE : ST_FILL;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      fill_dat_q <= '0;
      fill_cnt_q <= '0;
      fill_len_q <= '0;
      fill_msb_q <= 1'b0;
      out_dat_q  <= '0;
      out_cnt_q  <= '0;
      out_vld_q  <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      fill_dat_q <= fill_dat_d;
      fill_cnt_q <= fill_cnt_d;
      fill_len_q <= fill_len_d;
      fill_msb_q <= fill_msb_d;
      out_dat_q  <= out_dat_d;
      out_cnt_q  <= out_cnt_d;
      out_vld_q  <= out_vld_d;
      done_q     <= drain;
    end
  end

endmodule

// File: tb/tb_input_chaining_pipe.sv
// tb/tb_input_chaining_pipe.sv - directed self-checking bench for input_chaining_pipe
module tb_input_chaining_pipe;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic [2:0]  cfg_len;
  logic        cfg_msb_first;
  logic [15:0] in_dat;
  logic        in_vld;
  logic        in_rdy;
  logic        flush;
  logic [63:0] out_dat;
  logic        out_vld;
  logic        out_rdy;
  logic [2:0]  out_cnt;
  logic        done;

  int n_total = 0;
  int n_pass  = 0;

  input_chaining_pipe dut (
    .clk           (clk),
    .rst           (rst),
    .en            (en),
    .cfg_len       (cfg_len),
    .cfg_msb_first (cfg_msb_first),
    .in_dat        (in_dat),
    .in_vld        (in_vld),
    .in_rdy        (in_rdy),
    .flush         (flush),
    .out_dat       (out_dat),
    .out_vld       (out_vld),
    .out_rdy       (out_rdy),
    .out_cnt       (out_cnt),
    .done          (done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    if (obs !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    else n_pass++;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic word(input logic [15:0] d);
    in_vld = 1'b1;
    in_dat = d;
    step();
  endtask

  initial begin
    rst = 1'b1; en = 1'b1; cfg_len = 3'd4; cfg_msb_first = 1'b0;
    in_dat = '0; in_vld = 1'b0; flush = 1'b0; out_rdy = 1'b1;
    step(); step();
    chk("rst_in_rdy",  {63'd0, in_rdy},  64'd0);
    chk("rst_out_vld", {63'd0, out_vld}, 64'd0);
    chk("rst_out_dat", out_dat,          64'd0);
    chk("rst_out_cnt", {61'd0, out_cnt}, 64'd0);
    chk("rst_done",    {63'd0, done},    64'd0);
    rst = 1'b0;
    step();
    chk("idle_in_rdy", {63'd0, in_rdy}, 64'd1);

    // Basic lsb-first with a gap after the first word
    word(16'd1);
    in_vld = 1'b0; step();
    chk("gap_no_out", {63'd0, out_vld}, 64'd0);
    word(16'd2); word(16'd3); word(16'd4);
    chk("lsb_vld", {63'd0, out_vld}, 64'd1);
    chk("lsb_dat", out_dat, 64'h0004_0003_0002_0001);
    chk("lsb_cnt", {61'd0, out_cnt}, 64'd4);
    in_vld = 1'b0; step();
    chk("lsb_vld_drop", {63'd0, out_vld}, 64'd0);
    chk("lsb_done", {63'd0, done}, 64'd1);
    step();
    chk("lsb_done_pulse", {63'd0, done}, 64'd0);

    // msb-first with len clamp (0 -> 4)
    cfg_len = 3'd0; cfg_msb_first = 1'b1;
    word(16'hA); word(16'hB);
    cfg_len = 3'd2; cfg_msb_first = 1'b0;   // mid-group change must be ignored
    word(16'hC);
    chk("msb_not_early", {63'd0, out_vld}, 64'd0);
    word(16'hD);
    chk("msb_dat", out_dat, 64'h000A_000B_000C_000D);
    chk("msb_cnt", {61'd0, out_cnt}, 64'd4);
    in_vld = 1'b0; step();

    // Backpressure, L=2
    cfg_len = 3'd2; cfg_msb_first = 1'b0; out_rdy = 1'b0;
    word(16'd1); word(16'd2); word(16'd3); word(16'd4);
    chk("bp_hold_vld", {63'd0, out_vld}, 64'd1);
    chk("bp_hold_dat", out_dat, 64'h0000_0000_0002_0001);
    chk("bp_full_rdy", {63'd0, in_rdy}, 64'd0);
    word(16'd5);   // offered while FULL, not accepted
    chk("bp_full_rdy2", {63'd0, in_rdy}, 64'd0);
    chk("bp_hold_dat2", out_dat, 64'h0000_0000_0002_0001);
    out_rdy = 1'b1;
    step();        // drain group 1, group 2 loads on the same edge
    chk("bp_g2_vld", {63'd0, out_vld}, 64'd1);
    chk("bp_g2_dat", out_dat, 64'h0000_0000_0004_0003);
    chk("bp_rdy_back", {63'd0, in_rdy}, 64'd1);
    chk("bp_done1", {63'd0, done}, 64'd1);
    word(16'd5);
    chk("bp_g2_drained", {63'd0, out_vld}, 64'd0);
    word(16'd6);
    chk("bp_g3_dat", out_dat, 64'h0000_0000_0006_0005);
    chk("bp_g3_cnt", {61'd0, out_cnt}, 64'd2);
    in_vld = 1'b0; step();

    // Flush partial groups
    cfg_len = 3'd4;
    word(16'd7); word(16'd8);
    in_vld = 1'b0; flush = 1'b1; step();
    flush = 1'b0;
    chk("fl2_vld", {63'd0, out_vld}, 64'd1);
    chk("fl2_cnt", {61'd0, out_cnt}, 64'd2);
    chk("fl2_dat", out_dat, 64'h0000_0000_0008_0007);
    word(16'd7); word(16'd8);
    flush = 1'b1; word(16'd9);
    flush = 1'b0; in_vld = 1'b0;
    chk("fl3_cnt", {61'd0, out_cnt}, 64'd3);
    chk("fl3_dat", out_dat, 64'h0000_0009_0008_0007);
    step();
    flush = 1'b1; step();
    flush = 1'b0;
    chk("fl_empty_ignored", {63'd0, out_vld}, 64'd0);

    // en gating
    word(16'h11); word(16'h12);
    en = 1'b0; in_dat = 16'h99;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("en_low_rdy", {63'd0, in_rdy}, 64'd0);
      chk("en_low_vld", {63'd0, out_vld}, 64'd0);
    end
    en = 1'b1;
    word(16'h13); word(16'h14);
    chk("en_dat", out_dat, 64'h0014_0013_0012_0011);
    chk("en_cnt", {61'd0, out_cnt}, 64'd4);
    in_vld = 1'b0; step();

    // Reset mid-group
    word(16'd1); word(16'd2); word(16'd3);
    in_vld = 1'b0; rst = 1'b1; step();
    chk("mrst_vld", {63'd0, out_vld}, 64'd0);
    chk("mrst_dat", out_dat, 64'd0);
    chk("mrst_cnt", {61'd0, out_cnt}, 64'd0);
    chk("mrst_rdy", {63'd0, in_rdy}, 64'd0);
    rst = 1'b0;
    word(16'd5); word(16'd6); word(16'd7);
    chk("mrst_no_residue", {63'd0, out_vld}, 64'd0);
    word(16'd8);
    chk("mrst_dat2", out_dat, 64'h0008_0007_0006_0005);
    chk("mrst_cnt2", {61'd0, out_cnt}, 64'd4);
    in_vld = 1'b0; step();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/input_chaining_pipe.md
Name: input_chaining_pipe

Overview:
- Parametrised successor to the single-width input chainer.
- Packs a stream of DATA_WID-bit words into one MAX_CHAIN*DATA_WID-bit bus using valid/ready on both sides.
- Group length and packing order are set at runtime; a flush command emits a partial group.
- A second (output) buffer lets the next group fill while the current one waits on a stalled consumer. Sits between the ifmap/weight input FIFOs and the PE-array double buffers.

Parameters:
- DATA_WID, 16, width of one input word
- MAX_CHAIN, 4, maximum words per group (>=2)
- CNT_WID, $clog2(MAX_CHAIN+1), width of the count and length fields

Ports:
- clk  in  1  clock; all logic on rising edge
- rst  in  1  synchronous, active-high reset
- en  in  1  enable input acceptance; partial group retained while low
- cfg_len  in  CNT_WID  words per group; sampled at group start
- cfg_msb_first  in  1  packing order; sampled at group start
- in_dat  in  DATA_WID  input word
- in_vld  in  1  input word valid
- in_rdy  out  1  block can accept in_dat this cycle
- flush  in  1  close the current partial group
- out_dat  out  MAX_CHAIN*DATA_WID  packed group
- out_vld  out  1  out_dat/out_cnt valid
- out_rdy  in  1  consumer accepts the group
- out_cnt  out  CNT_WID  number of valid words in out_dat
- done  out  1  one-cycle pulse when a group is consumed

Behaviour:
- Reset: in_rdy=0, out_vld=0, out_dat=0, out_cnt=0, done=0; fill count=0; fill buffer zeroed. Reset mid-group or mid-stall discards all data. Reset beats every other input.
- Accept: a word is accepted when in_vld && in_rdy at the clock edge.
- in_rdy: in_rdy = en && (fill state != FULL). It is combinational from en and registered state only, never from in_vld.
- Effective length: L = cfg_len, sampled on the first accepted word of a group (count==0). If cfg_len==0 or cfg_len>MAX_CHAIN, L=MAX_CHAIN. Changing cfg_* mid-group has no effect.
- Packing order:
  - lsb-first (order=0): word k (0-based) goes to out_dat[k*DATA_WID +: DATA_WID].
  - msb-first (order=1): word k goes to slot MAX_CHAIN-1-k.
  - Unused slots are zero.
- Fill FSM states:
  - IDLE: count==0. Accept -> FILL.
  - FILL: count in 1..L-1. Accepting the L-th word, or flush -> COMMIT.
  - FULL: group complete but the output buffer is occupied and not draining.
- Commit:
  - Transfer the fill buffer to the output buffer, set out_vld=1, out_cnt=count.
  - Clear the fill buffer and return to IDLE, all in the same edge.
  - If the output buffer is occupied, the fill goes to FULL and stays until the output buffer frees.
- Output drain: the output buffer drains when out_vld && out_rdy. If a commit is pending that same cycle, the new group loads on the same edge (out_vld stays 1, no bubble). Otherwise out_vld goes to 0.
- Throughput: with out_rdy held at 1, a group of L words produces a new out_vld every L cycles, sustained.
- Latency: out_vld rises on the edge after the last word of a group is accepted (1 cycle).
- Flush:
  - flush && count>0 (count includes a word accepted that same cycle) commits a partial group with out_cnt=count.
  - flush with count==0 and no accept is ignored.
  - flush in FULL is ignored.
- done: registered one-cycle pulse on the edge following an out_vld && out_rdy handshake.
- out_dat/out_cnt: stable while out_vld && !out_rdy.
- en low: in_rdy=0. Fill contents and count are held, and the output side keeps draining. When en returns, filling resumes at the held count.
- Simultaneous events in one cycle are all honoured: accept of the L-th word, drain of the output buffer, and done from the previous drain.

Test Plan:
- Basic lsb-first: L=4, order=0, words 1,2,3,4 with in_vld gap after word 1, out_rdy=1 -> out_dat=0x0004_0003_0002_0001, out_cnt=4, out_vld for 1 cycle, done the next cycle.
- msb-first and clamp: cfg_len=0 (-> 4), order=1, words 0xA,0xB,0xC,0xD -> out_dat=0x000A_000B_000C_000D.
- Backpressure: L=2, 6 words back-to-back, out_rdy=0 for 5 cycles.
  - First group 0x0002_0001 is held stable.
  - Second group fills, then in_rdy=0 (FULL).
  - On release, groups emit in order with no loss or duplicate, and in_rdy returns 1 the cycle after the drain.
- Flush partial: L=4, words 7,8 then flush (flush also with a third word 9 in the same cycle) -> out_cnt=2 with out_dat=0x0000_0000_0008_0007; and out_cnt=3 with upper slot zero.
- en gating: L=4, 2 words, en=0 for 3 cycles with in_vld=1 -> in_rdy=0, nothing accepted. en=1, 2 more words -> single group of 4 in the correct order.
- Reset mid-group: 3 words accepted, rst=1 for 1 cycle -> all outputs 0. The next 4 words form a fresh group with no residue.
